// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants and types for the pipeline hazard/stall control block.
package hazard_stall_unit_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WAIT_CNT_W = 8;
  localparam int unsigned PERF_CNT_W = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b01;
  localparam logic [1:0] WB_SEL_MEM = 2'b10;
  localparam logic [1:0] WB_SEL_PC  = 2'b11;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_unit_perf_counters.sv
// Wrapping 32-bit stall/flush/load-use event counters; only built with HAZARD_PERF_EN.
`ifdef HAZARD_PERF_EN
module hazard_perf_counters
  import hazard_stall_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_flush_evt,
  input  logic                  i_load_use,
  output logic [PERF_CNT_W-1:0] o_stall_cnt,
  output logic [PERF_CNT_W-1:0] o_flush_cnt,
  output logic [PERF_CNT_W-1:0] o_loaduse_cnt
);

  logic [PERF_CNT_W-1:0] r_stall_cnt;
  logic [PERF_CNT_W-1:0] r_flush_cnt;
  logic [PERF_CNT_W-1:0] r_loaduse_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_loaduse_cnt <= '0;
    end else begin
      if (i_stall)     r_stall_cnt   <= r_stall_cnt + PERF_CNT_W'(1);
      if (i_flush_evt) r_flush_cnt   <= r_flush_cnt + PERF_CNT_W'(1);
      if (i_load_use)  r_loaduse_cnt <= r_loaduse_cnt + PERF_CNT_W'(1);
    end
  end

  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_loaduse_cnt = r_loaduse_cnt;

endmodule
`endif

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush control for hazards the bypass network cannot resolve.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_unit #(
  parameter int unsigned REG_ADDR_W  = hazard_stall_unit_pkg::REG_ADDR_W,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_addr_exe,
  input  logic                  we_reg_exe,
  input  logic [1:0]            wb_sel_exe,
  input  logic                  if_req,
  input  logic                  if_ack,
  input  logic                  mem_req_mem,
  input  logic                  mem_ack_mem,
  input  logic                  redirect_exe,
  input  logic                  trap_wb,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  stall_idexe,
  output logic                  stall_exemem,
  output logic                  stall_memwb,
  output logic                  flush_ifid,
  output logic                  flush_idexe,
  output logic                  flush_exemem,
  output logic                  flush_memwb,
  output logic                  if_kill,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_loaduse_cnt,
`endif
  output logic                  mem_timeout
);

  import hazard_stall_unit_pkg::*;

  hz_state_e             r_state;
  hz_state_e             w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic                  r_mem_timeout;

  logic w_mem_wait;
  logic w_if_wait;
  logic w_load_use;
  logic w_lu_bubble;
  logic w_discard;

  assign w_mem_wait = mem_req_mem & ~mem_ack_mem;
  assign w_if_wait  = if_req & ~if_ack;
  assign w_discard  = (r_state == DISCARD);
  assign w_load_use = (wb_sel_exe == WB_SEL_MEM) & we_reg_exe & (rd_addr_exe != '0) &
                      ((rs1_used_id & (rs1_addr_id == rd_addr_exe)) |
                       (rs2_used_id & (rs2_addr_id == rd_addr_exe)));

  // Priority-ordered stall/flush decode plus discard FSM next state.
  always_comb begin
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idexe  = 1'b0;
    stall_exemem = 1'b0;
    stall_memwb  = 1'b0;
    flush_ifid   = 1'b0;
    flush_idexe  = 1'b0;
    flush_exemem = 1'b0;
    flush_memwb  = 1'b0;
    if_kill      = 1'b0;
    w_lu_bubble  = 1'b0;
    w_state_nxt  = r_state;

    if (trap_wb) begin
      flush_ifid   = 1'b1;
      flush_idexe  = 1'b1;
      flush_exemem = 1'b1;
      flush_memwb  = 1'b1;
    end else if (w_mem_wait) begin
      stall_pc     = 1'b1;
      stall_ifid   = 1'b1;
      stall_idexe  = 1'b1;
      stall_exemem = 1'b1;
      flush_memwb  = 1'b1;
    end else if (redirect_exe) begin
      flush_ifid   = 1'b1;
      flush_idexe  = 1'b1;
    end else begin
      if (w_load_use) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        flush_idexe = 1'b1;
        w_lu_bubble = 1'b1;
      end
      // The fetch outstanding during DISCARD is the stale one, so it must not hold the PC.
      if (w_if_wait && !w_discard) begin
        stall_pc   = 1'b1;
        flush_ifid = 1'b1;
      end
    end

    if (w_discard) begin
      flush_ifid = 1'b1;
      if_kill    = 1'b1;
    end

    case (r_state)
      RUN:     if ((redirect_exe || trap_wb) && w_if_wait) w_state_nxt = DISCARD;
      DISCARD: if (if_ack) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase

    if (rst) begin
      stall_pc     = 1'b0;
      stall_ifid   = 1'b0;
      stall_idexe  = 1'b0;
      stall_exemem = 1'b0;
      stall_memwb  = 1'b0;
      flush_ifid   = 1'b1;
      flush_idexe  = 1'b1;
      flush_exemem = 1'b1;
      flush_memwb  = 1'b1;
      if_kill      = 1'b0;
      w_lu_bubble  = 1'b0;
    end
  end

  // Saturating data-memory wait counter.
  always_comb begin
    w_wait_cnt_nxt = '0;
    if (w_mem_wait && !trap_wb) begin
      w_wait_cnt_nxt = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= (w_wait_cnt_nxt == WAIT_CNT_W'(MEM_TIMEOUT)) &&
                       (r_wait_cnt != WAIT_CNT_W'(MEM_TIMEOUT));
    end
  end

  assign mem_timeout = r_mem_timeout & ~rst;

`ifdef HAZARD_PERF_EN
  hazard_perf_counters u_perf (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (stall_pc),
    .i_flush_evt   (~rst & (redirect_exe | trap_wb)),
    .i_load_use    (w_lu_bubble),
    .o_stall_cnt   (perf_stall_cnt),
    .o_flush_cnt   (perf_flush_cnt),
    .o_loaduse_cnt (perf_loaduse_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (perf checks under HAZARD_PERF_EN).
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_addr_id, rs2_addr_id, rd_addr_exe;
  logic       rs1_used_id, rs2_used_id, we_reg_exe;
  logic [1:0] wb_sel_exe;
  logic       if_req, if_ack, mem_req_mem, mem_ack_mem, redirect_exe, trap_wb;
  logic       stall_pc, stall_ifid, stall_idexe, stall_exemem, stall_memwb;
  logic       flush_ifid, flush_idexe, flush_exemem, flush_memwb, if_kill, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_loaduse_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_addr_exe(rd_addr_exe), .we_reg_exe(we_reg_exe), .wb_sel_exe(wb_sel_exe),
    .if_req(if_req), .if_ack(if_ack), .mem_req_mem(mem_req_mem), .mem_ack_mem(mem_ack_mem),
    .redirect_exe(redirect_exe), .trap_wb(trap_wb),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idexe(stall_idexe),
    .stall_exemem(stall_exemem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idexe(flush_idexe), .flush_exemem(flush_exemem),
    .flush_memwb(flush_memwb), .if_kill(if_kill),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_loaduse_cnt(perf_loaduse_cnt),
`endif
    .mem_timeout(mem_timeout)
  );

  // {stall pc,ifid,idexe,exemem,memwb, flush ifid,idexe,exemem,memwb, if_kill, mem_timeout}
  logic [10:0] obs;
  assign obs = {stall_pc, stall_ifid, stall_idexe, stall_exemem, stall_memwb,
                flush_ifid, flush_idexe, flush_exemem, flush_memwb, if_kill, mem_timeout};

  localparam logic [10:0] V_IDLE  = 11'b00000_0000_0_0;
  localparam logic [10:0] V_RST   = 11'b00000_1111_0_0;
  localparam logic [10:0] V_LU    = 11'b11000_0100_0_0;
  localparam logic [10:0] V_LU_IF = 11'b11000_1100_0_0;
  localparam logic [10:0] V_MW    = 11'b11110_0001_0_0;
  localparam logic [10:0] V_MW_TO = 11'b11110_0001_0_1;
  localparam logic [10:0] V_RDR   = 11'b00000_1100_0_0;
  localparam logic [10:0] V_RDR_K = 11'b00000_1100_1_0;
  localparam logic [10:0] V_TRAP  = 11'b00000_1111_0_0;
  localparam logic [10:0] V_IFW   = 11'b10000_1000_0_0;
  localparam logic [10:0] V_DISC  = 11'b00000_1000_1_0;
  localparam logic [10:0] V_MW_D  = 11'b11110_1001_1_0;

  task automatic chk(input string tag, input logic [10:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_addr_id = '0; rs2_addr_id = '0; rd_addr_exe = '0;
    rs1_used_id = 0; rs2_used_id = 0; we_reg_exe = 0; wb_sel_exe = 2'b01;
    if_req = 0; if_ack = 0; mem_req_mem = 0; mem_ack_mem = 0;
    redirect_exe = 0; trap_wb = 0;
  endtask

  // Advance to the next drive point (falling edge), inputs may then be changed.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Hold mem_wait for 260 cycles; the timeout pulse must appear only after the 255th.
  task automatic timeout_run(input string tag);
    for (int i = 0; i < 260; i++) begin
      cyc(); idle_inputs(); mem_req_mem = 1; #1;
      chk(tag, (i == 255) ? V_MW_TO : V_MW);
    end
    cyc(); idle_inputs(); #1; chk({tag, "_drop"}, V_IDLE);
  endtask

  task automatic load_use_vec(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                              input logic [4:0] r2, input logic u2, input logic [1:0] sel);
    idle_inputs();
    rd_addr_exe = rd; we_reg_exe = 1; wb_sel_exe = sel;
    rs1_addr_id = r1; rs1_used_id = u1; rs2_addr_id = r2; rs2_used_id = u2;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1; chk("reset_comb", V_RST);
    cyc(); #1; chk("reset_held", V_RST);
    cyc(); rst = 0; #1; chk("idle", V_IDLE);

    // Load-use interlock
    cyc(); load_use_vec(5'd5, 5'd5, 1, 5'd0, 0, 2'b10); #1; chk("lu_rs1", V_LU);
    cyc(); load_use_vec(5'd6, 5'd1, 1, 5'd2, 1, 2'b01); #1; chk("lu_next_alu", V_IDLE);
    cyc(); load_use_vec(5'd0, 5'd0, 1, 5'd0, 0, 2'b10); #1; chk("lu_rd0", V_IDLE);
    cyc(); load_use_vec(5'd9, 5'd1, 0, 5'd9, 1, 2'b10); #1; chk("lu_rs2", V_LU);
    cyc(); load_use_vec(5'd9, 5'd9, 0, 5'd3, 1, 2'b10); #1; chk("lu_unused", V_IDLE);
    cyc(); load_use_vec(5'd9, 5'd9, 1, 5'd0, 0, 2'b01); #1; chk("lu_alu", V_IDLE);
    cyc(); load_use_vec(5'd7, 5'd7, 1, 5'd0, 0, 2'b10); we_reg_exe = 0; #1; chk("lu_nowe", V_IDLE);
    cyc(); load_use_vec(5'd5, 5'd5, 1, 5'd0, 0, 2'b10); if_req = 1; #1; chk("lu_ifwait", V_LU_IF);
    cyc(); idle_inputs(); if_req = 1; #1; chk("if_wait", V_IFW);
    cyc(); idle_inputs(); if_req = 1; if_ack = 1; #1; chk("if_ack", V_IDLE);

    // Memory wait stalls and timeout
    for (int i = 0; i < 3; i++) begin
      cyc(); idle_inputs(); mem_req_mem = 1; #1; chk("mem_wait3", V_MW);
    end
    cyc(); idle_inputs(); mem_req_mem = 1; mem_ack_mem = 1; #1; chk("mem_ack", V_IDLE);
    cyc(); idle_inputs(); load_use_vec(5'd5, 5'd5, 1, 5'd0, 0, 2'b10);
    mem_req_mem = 1; redirect_exe = 1; #1; chk("mw_over_rdr_lu", V_MW);
    cyc(); idle_inputs(); #1; chk("mw_clear", V_IDLE);
    timeout_run("timeout_a");

    // Trap dominates and clears the wait counter
    for (int i = 0; i < 10; i++) begin
      cyc(); idle_inputs(); mem_req_mem = 1; #1;
    end
    chk("mw_pre_trap", V_MW);
    cyc(); load_use_vec(5'd5, 5'd5, 1, 5'd0, 0, 2'b10); mem_req_mem = 1; trap_wb = 1; #1;
    chk("trap_prio", V_TRAP);
    timeout_run("timeout_after_trap");

    // Redirect with outstanding fetch -> DISCARD
    cyc(); idle_inputs(); redirect_exe = 1; if_req = 1; #1; chk("rdr_ifwait", V_RDR);
    cyc(); idle_inputs(); if_req = 1; #1; chk("disc_1", V_DISC);
    cyc(); idle_inputs(); if_req = 1; #1; chk("disc_2", V_DISC);
    cyc(); idle_inputs(); if_req = 1; if_ack = 1; #1; chk("disc_ack", V_DISC);
    cyc(); idle_inputs(); #1; chk("disc_exit", V_IDLE);
    cyc(); idle_inputs(); redirect_exe = 1; if_req = 1; if_ack = 1; #1; chk("rdr_ack", V_RDR);
    cyc(); idle_inputs(); #1; chk("rdr_ack_nodisc", V_IDLE);
    cyc(); idle_inputs(); redirect_exe = 1; if_req = 1; #1; chk("rdr_again", V_RDR);
    cyc(); idle_inputs(); redirect_exe = 1; if_req = 1; #1; chk("rdr_in_disc", V_RDR_K);
    cyc(); idle_inputs(); if_req = 1; #1; chk("disc_stay", V_DISC);
    cyc(); idle_inputs(); if_ack = 1; #1; chk("disc_ack2", V_DISC);
    cyc(); idle_inputs(); trap_wb = 1; if_req = 1; #1; chk("trap_ifwait", V_TRAP);
    cyc(); idle_inputs(); #1; chk("trap_disc", V_DISC);
    cyc(); idle_inputs(); if_ack = 1; #1; chk("trap_disc_ack", V_DISC);
    cyc(); idle_inputs(); #1; chk("trap_disc_exit", V_IDLE);

    // Reset while in DISCARD with a partial wait count
    cyc(); idle_inputs(); redirect_exe = 1; if_req = 1; #1; chk("rdr_pre_rst", V_RDR);
    for (int i = 0; i < 10; i++) begin
      cyc(); idle_inputs(); if_req = 1; mem_req_mem = 1; #1;
    end
    chk("mw_in_disc", V_MW_D);
    cyc(); idle_inputs(); if_req = 1; mem_req_mem = 1; rst = 1; #1; chk("rst_in_disc", V_RST);
    cyc(); rst = 0; idle_inputs(); #1; chk("post_rst", V_IDLE);
    timeout_run("timeout_after_rst");

`ifdef HAZARD_PERF_EN
    cyc(); idle_inputs(); rst = 1;
    cyc(); rst = 0; #1;
    chk32("perf_stall_rst", perf_stall_cnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); load_use_vec(5'd3, 5'd3, 1, 5'd0, 0, 2'b10);
      cyc(); idle_inputs();
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); idle_inputs(); redirect_exe = 1;
      cyc(); idle_inputs();
    end
    cyc(); #1;
    chk32("perf_loaduse", perf_loaduse_cnt, 32'd4);
    chk32("perf_flush", perf_flush_cnt, 32'd2);
    chk32("perf_stall_ge4", {31'd0, (perf_stall_cnt >= 32'd4)}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline control block that handles the hazards the bypass network cannot resolve. It takes the same ID/EXE/MEM/WB hazard information that forwarding consumes and drives the stall and flush enables of the pipeline registers.
- Covers load-use interlock, instruction/data memory wait states, branch redirects and WB-stage traps.
- Holds a registered discard state so a stale instruction fetch that completes after a redirect is dropped.

Parameters:
REG_ADDR_W, 5, register address width
MEM_TIMEOUT, 255, data-memory wait cycles before mem_timeout pulses (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rs1_addr_id  in  5  ID source 1 address
rs2_addr_id  in  5  ID source 2 address
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_addr_exe  in  5  EXE destination
we_reg_exe  in  1  EXE writes register
wb_sel_exe  in  2  EXE writeback select; 2'b10 = load
if_req  in  1  fetch request outstanding this cycle
if_ack  in  1  fetch data valid
mem_req_mem  in  1  MEM-stage load/store request
mem_ack_mem  in  1  data memory response
redirect_exe  in  1  taken branch/jump resolved in EXE
trap_wb  in  1  trap or mret committed in WB
stall_pc, stall_ifid, stall_idexe, stall_exemem, stall_memwb  out  1 each  hold register
flush_ifid, flush_idexe, flush_exemem, flush_memwb  out  1 each  load bubble
if_kill  out  1  IF must drop returning data and re-issue at current PC
mem_timeout  out  1  one-cycle pulse, data memory exceeded MEM_TIMEOUT

Behaviour:
- While rst=1:
  - all stall_* = 0, all flush_* = 1, if_kill = 0, mem_timeout = 0.
  - discard = 0, wait counter = 0, FSM = RUN.
- Combinational priority, highest first:
  - trap_wb: flush_ifid, flush_idexe, flush_exemem, flush_memwb = 1; no stalls.
  - mem_wait (mem_req_mem & !mem_ack_mem): stall_pc, stall_ifid, stall_idexe, stall_exemem = 1; flush_memwb = 1.
  - redirect_exe: flush_ifid = flush_idexe = 1; PC not stalled.
  - load_use: wb_sel_exe == 2'b10 & we_reg_exe & rd_addr_exe != 0 & ((rs1_used_id & rs1 == rd) | (rs2_used_id & rs2 == rd)).
    - Effect: stall_pc = stall_ifid = 1, flush_idexe = 1.
    - Exactly one bubble; the next cycle forwards from MEM.
  - if_wait (if_req & !if_ack): stall_pc = 1, flush_ifid = 1.
  - A lower-priority condition's flushes and stalls are suppressed when a higher one is active.
  - Exception: if_wait's flush_ifid ORs with load_use.
- FSM, registered: RUN / DISCARD.
  - RUN -> DISCARD when (redirect_exe | trap_wb) & if_req & !if_ack in the same cycle.
  - DISCARD: if_kill = 1, flush_ifid = 1, stall_pc = 0.
  - DISCARD -> RUN on the cycle if_ack = 1; that response is dropped.
  - A further redirect while in DISCARD stays in DISCARD.
  - Redirect with if_ack = 1 in the same cycle: no DISCARD, because flush_ifid already kills the response.
- Wait counter, 8 bits:
  - Increments each mem_wait cycle, saturating at 255.
  - Clears when mem_wait = 0 or trap_wb = 1.
  - mem_timeout pulses for exactly one cycle when the counter reaches MEM_TIMEOUT.
- Reset mid-operation: synchronous reset overrides everything on the next edge, including DISCARD and a partial count.
- Latency: all stall/flush outputs are same-cycle combinational from inputs plus state; the state update takes one cycle.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0] and perf_loaduse_cnt[31:0].
  - perf_stall_cnt increments on any cycle with stall_pc = 1.
  - perf_flush_cnt increments on the cycles redirect_exe or trap_wb is active.
  - perf_loaduse_cnt increments on load_use cycles.
  - All counters wrap at 2^32 and are cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: WB_SEL_ALU = 2'b01, WB_SEL_MEM = 2'b10, WB_SEL_PC = 2'b11, the FSM state enum (RUN, DISCARD), REG_ADDR_W.
- One natural sub-module: hazard_perf_counters, instantiated only under HAZARD_PERF_EN.

Test Plan:
1. Load x5 in EXE (wb_sel_exe = 2'b10, we = 1, rd = 5) with ID add rs1 = 5, rs1_used = 1 -> one cycle with stall_pc = stall_ifid = flush_idexe = 1; next cycle all 0. Repeat with rd = 0 -> no stall.
2. mem_req_mem = 1, mem_ack_mem low for 3 cycles -> 3 cycles of stall_pc..stall_exemem = 1 and flush_memwb = 1. Hold 255 cycles -> mem_timeout high for exactly 1 cycle.
3. redirect_exe with if_req = 1, if_ack = 0, then ack 2 cycles later -> DISCARD for 2 cycles with if_kill = 1, back to RUN after the ack. Redirect with same-cycle ack -> no DISCARD.
4. trap_wb together with mem_wait and load_use -> only the four flushes asserted, no stalls, counter cleared.
5. rst asserted while in DISCARD with counter = 10 -> next cycle state RUN, counter 0, flushes all 1, if_kill = 0.
6. HAZARD_PERF_EN: 4 load-use bubbles plus 2 redirects -> perf_loaduse_cnt = 4, perf_flush_cnt = 2, perf_stall_cnt ≥ 4.
